vga_timing_gen: RTL

Generates VGA 640x480@60 Hz raster timing from the 50 MHz system clock. Produces the 10-bit `horizontal`/`vertical` pixel counters that the zone-selection stage consumes. Also produces active-low `hsync`/`vsync` to the DAC connector, plus `video_on`, `pixel_tick` and `frame_start` for downstream colour logic. It is the first stage of the VGA pipeline; all raster-position consumers take their coordinates from this block.

---
 rtl/vga_timing_gen.sv | 116 +++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator (640x480@60 Hz by default).
// A clock divider produces the pixel rate. Horizontal and vertical counters
// step on each pixel tick. Sync, blanking and frame markers are decoded
// combinationally from the registered counters, so they match the counters
// in the same cycle.
// Optional feature: define VGA_FRAME_CNT_EN to add an 8-bit frame_count output.
module vga_timing_gen #(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] horizontal,
   output logic [9:0] vertical,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       pixel_tick,
   output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [7:0] frame_count
`endif
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Wrap points of the counters.
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

   // Decode boundaries are 11 bits wide, so an end point equal to 1024 still compares correctly.
   localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
   localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
   localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   // Elaboration-time guard on the geometry and divider range.
   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end
   if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_check
      $error("vga_timing_gen: CLK_DIV must be in 1..16");
   end

   logic [3:0]  div;
   logic [10:0] h_ext;
   logic [10:0] v_ext;
   logic        line_end;

   assign h_ext    = {1'b0, horizontal};
   assign v_ext    = {1'b0, vertical};
   assign line_end = (horizontal == H_LAST);

   // Pixel-rate strobe, decoded from the divider register.
   assign pixel_tick = (div == DIV_LAST);

   // Divider: counts system clocks within one pixel period.
   always_ff @(posedge clk) begin
      if (reset) begin
         div <= '0;
      end else if (div == DIV_LAST) begin
         div <= '0;
      end else begin
         div <= div + 4'd1;
      end
   end

   // Raster counters: advance on a pixel tick. The vertical counter steps at the end of each line.
   always_ff @(posedge clk) begin
      if (reset) begin
         horizontal <= '0;
         vertical   <= '0;
      end else if (pixel_tick) begin
         if (line_end) begin
            horizontal <= '0;
            if (vertical == V_LAST) begin
               vertical <= '0;
            end else begin
               vertical <= vertical + 10'd1;
            end
         end else begin
            horizontal <= horizontal + 10'd1;
         end
      end
   end

   // Sync pulses are active low inside their windows.
   assign hsync       = !((h_ext >= HS_START) && (h_ext < HS_END));
   assign vsync       = !((v_ext >= VS_START) && (v_ext < VS_END));
   assign video_on    = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
   assign frame_start = pixel_tick && line_end && (vertical == V_LAST);

`ifdef VGA_FRAME_CNT_EN
   // Frame counter: counts completed frames and wraps naturally at 8 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_count <= '0;
      end else if (frame_start) begin
         frame_count <= frame_count + 8'd1;
      end
   end
`endif

endmodule
